// File: rtl/md_audio_mixer_if.sv
`default_nettype none
// ============================================================================
// md_audio_mixer_if : stereo sample stream from the mixer to the serializer
// Revision: 1.0
// ============================================================================
interface md_audio_mixer_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_l;
  logic [15:0] out_r;

  modport master (output out_valid, out_l, out_r, input out_ready);
  modport slave  (input out_valid, out_l, out_r, output out_ready);
endinterface
`default_nettype wire

// File: rtl/md_audio_mixer.sv
`default_nettype none
// ============================================================================
// md_audio_mixer : FM + PSG stereo mix, box-filter decimator, FWFT output FIFO
// Revision: 1.0
// ============================================================================
module md_audio_mixer #(
  parameter int          DECIM_LOG2 = 10,
  parameter int          FM_GAIN    = 5,
  parameter logic [15:0] PSG_BIAS   = 16'h8000,
  parameter int          PSG_ATTN   = 2,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                    MCLK,
  input  logic                    SRES,
  input  logic                    EN,
  input  logic [8:0]              MOL,
  input  logic [8:0]              MOR,
  input  logic [15:0]             PSG,
  input  logic                    ovf_clr,
  output logic                    OVF,
  md_audio_mixer_if.master        out_if
);

  localparam int ACC_W = 20 + DECIM_LOG2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [DECIM_LOG2-1:0]     c_cnt_max = '1;
  localparam logic [PTR_W:0]            c_depth   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic signed [ACC_W-1:0]   c_sat_hi  = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0]   c_sat_lo  = ~c_sat_hi;

  logic signed [19:0]      w_psg_d, w_psg_s, w_fm_l, w_fm_r, w_mix_l, w_mix_r;
  logic signed [ACC_W-1:0] w_sum_l, w_sum_r, w_avg_l, w_avg_r;
  logic [15:0]             w_sat_l, w_sat_r;
  logic                    w_win_end, w_full, w_pop, w_push, w_drop, w_valid;

  logic [DECIM_LOG2-1:0]   r_cnt;
  logic signed [ACC_W-1:0] r_acc_l, r_acc_r;
  logic [15:0]             r_mem_l [FIFO_DEPTH];
  logic [15:0]             r_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]          r_count;
  logic                    r_ovf;

  function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > c_sat_hi)      return 16'h7FFF;
    else if (v < c_sat_lo) return 16'h8000;
    else                   return v[15:0];
  endfunction

  // 20-bit arithmetic wraps the bias subtraction into a proper signed value.
  assign w_psg_d = {4'b0, PSG} - {4'b0, PSG_BIAS};
  assign w_psg_s = w_psg_d >>> PSG_ATTN;
  assign w_fm_l  = {{11{MOL[8]}}, MOL};
  assign w_fm_r  = {{11{MOR[8]}}, MOR};
  assign w_mix_l = (w_fm_l <<< FM_GAIN) + w_psg_s;
  assign w_mix_r = (w_fm_r <<< FM_GAIN) + w_psg_s;

  assign w_sum_l = r_acc_l + {{DECIM_LOG2{w_mix_l[19]}}, w_mix_l};
  assign w_sum_r = r_acc_r + {{DECIM_LOG2{w_mix_r[19]}}, w_mix_r};
  assign w_avg_l = w_sum_l >>> DECIM_LOG2;
  assign w_avg_r = w_sum_r >>> DECIM_LOG2;
  assign w_sat_l = sat16(w_avg_l);
  assign w_sat_r = sat16(w_avg_r);

  assign w_win_end = EN && (r_cnt == c_cnt_max);

  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      r_cnt   <= '0;
      r_acc_l <= '0;
      r_acc_r <= '0;
    end else if (!EN || w_win_end) begin
      r_cnt   <= '0;
      r_acc_l <= '0;
      r_acc_r <= '0;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
      r_acc_l <= w_sum_l;
      r_acc_r <= w_sum_r;
    end
  end

  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == c_depth);
  assign w_pop   = w_valid && out_if.out_ready;
  assign w_push  = w_win_end && (!w_full || w_pop);
  assign w_drop  = w_win_end && w_full && !w_pop;

  always_ff @(posedge MCLK) begin
    if (w_push) begin
      r_mem_l[r_wr_ptr] <= w_sat_l;
      r_mem_r[r_wr_ptr] <= w_sat_r;
    end
  end

  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign OVF              = r_ovf;
  assign out_if.out_valid = w_valid;
  assign out_if.out_l     = w_valid ? r_mem_l[r_rd_ptr] : 16'h0000;
  assign out_if.out_r     = w_valid ? r_mem_r[r_rd_ptr] : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_md_audio_mixer.sv
`default_nettype none
// ============================================================================
// tb_md_audio_mixer : directed vectors and sequences for md_audio_mixer
// Revision: 1.0
// ============================================================================
module tb_md_audio_mixer;

  logic        MCLK = 1'b0;
  logic        SRES = 1'b1;
  logic        EN = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [8:0]  MOL = '0;
  logic [8:0]  MOR = '0;
  logic [15:0] PSG = 16'h8000;
  logic        OVF, OVF7;

  int n_vec = 0;
  int n_bad = 0;

  md_audio_mixer_if bus ();
  md_audio_mixer_if bus7 ();

  md_audio_mixer dut (
    .MCLK(MCLK), .SRES(SRES), .EN(EN), .MOL(MOL), .MOR(MOR), .PSG(PSG),
    .ovf_clr(ovf_clr), .OVF(OVF), .out_if(bus)
  );

  md_audio_mixer #(.FM_GAIN(7)) dut7 (
    .MCLK(MCLK), .SRES(SRES), .EN(EN), .MOL(MOL), .MOR(MOR), .PSG(PSG),
    .ovf_clr(ovf_clr), .OVF(OVF7), .out_if(bus7)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    logic [8:0]  mol;
    logic [8:0]  mor;
    logic [15:0] psg;
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] l7;
    logic [15:0] r7;
  } vec_t;

  task automatic step(input int n);
    repeat (n) @(posedge MCLK);
    @(negedge MCLK);
  endtask

  task automatic chk(input string what, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", what, act, exp);
    end
  endtask

  task automatic chk_bit(input string what, input logic act, input logic exp);
    chk(what, {15'b0, act}, {15'b0, exp});
  endtask

  task automatic apply_reset();
    SRES = 1'b0;
    step(2);
    SRES = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    vec_t vecs [7];
    int   early;
    // gain-7 right channel for vec1: -32768 + 8191 = -24577 = 16'h9FFF
    vecs[0] = '{9'h010, 9'h1F0, 16'h8000, 16'h0200, 16'hFE00, 16'h0800, 16'hF800};
    vecs[1] = '{9'h0FF, 9'h100, 16'hFFFF, 16'h3FDF, 16'hFFFF, 16'h7FFF, 16'h9FFF};
    vecs[2] = '{9'h0FF, 9'h100, 16'h0000, 16'hFFE0, 16'hC000, 16'h5F80, 16'h8000};
    vecs[3] = '{9'h000, 9'h000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{9'h001, 9'h1FF, 16'h8004, 16'h0021, 16'hFFE1, 16'h0081, 16'hFF81};
    vecs[5] = '{9'h07F, 9'h181, 16'h9000, 16'h13E0, 16'hF420, 16'h4380, 16'hC480};
    vecs[6] = '{9'h000, 9'h000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

    bus.out_ready  = 1'b1;
    bus7.out_ready = 1'b1;
    #1 SRES = 1'b0;
    @(negedge MCLK);

    chk_bit("rst_valid", bus.out_valid, 1'b0);
    chk("rst_out_l", bus.out_l, 16'h0000);
    chk("rst_out_r", bus.out_r, 16'h0000);
    chk_bit("rst_ovf", OVF, 1'b0);

    // Constant input: first sample visible right after edge 1024, popped at 1025.
    MOL = 9'h010; MOR = 9'h1F0; PSG = 16'h8000; EN = 1'b1;
    apply_reset();
    step(1023);
    chk_bit("lat_not_yet", bus.out_valid, 1'b0);
    step(1);
    chk_bit("lat_valid", bus.out_valid, 1'b1);
    chk("lat_l", bus.out_l, 16'h0200);
    chk("lat_r", bus.out_r, 16'hFE00);
    step(1);
    chk_bit("lat_popped", bus.out_valid, 1'b0);
    step(1022);
    chk_bit("win2_not_yet", bus.out_valid, 1'b0);
    step(1);
    chk_bit("win2_valid", bus.out_valid, 1'b1);
    chk("win2_l", bus.out_l, 16'h0200);
    chk("win2_r", bus.out_r, 16'hFE00);

    for (int i = 0; i < 7; i++) begin
      MOL = vecs[i].mol; MOR = vecs[i].mor; PSG = vecs[i].psg; EN = 1'b1;
      apply_reset();
      step(1023);
      chk_bit($sformatf("vec%0d_early", i), bus.out_valid, 1'b0);
      step(1);
      chk_bit($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
      chk($sformatf("vec%0d_l", i), bus.out_l, vecs[i].l);
      chk($sformatf("vec%0d_r", i), bus.out_r, vecs[i].r);
      chk_bit($sformatf("vec%0d_valid7", i), bus7.out_valid, 1'b1);
      chk($sformatf("vec%0d_l7", i), bus7.out_l, vecs[i].l7);
      chk($sformatf("vec%0d_r7", i), bus7.out_r, vecs[i].r7);
    end

    // Non-integer averages must floor: +0.5 -> 0, -0.5 -> -1.
    for (int p = 0; p < 2; p++) begin
      MOL = '0; MOR = '0; PSG = 16'h8000; EN = 1'b1;
      apply_reset();
      for (int i = 0; i < 1024; i++) begin
        PSG = i[0] ? 16'h8000 : ((p == 0) ? 16'h8004 : 16'h7FFC);
        step(1);
      end
      chk_bit($sformatf("floor%0d_valid", p), bus.out_valid, 1'b1);
      chk($sformatf("floor%0d_l", p), bus.out_l, (p == 0) ? 16'h0000 : 16'hFFFF);
      chk($sformatf("floor%0d_r", p), bus.out_r, (p == 0) ? 16'h0000 : 16'hFFFF);
    end

    // Stalled consumer for 6 windows: 4 held, windows 5 and 6 dropped.
    bus.out_ready = 1'b0;
    MOR = '0; PSG = 16'h8000; MOL = 9'd1; EN = 1'b1;
    apply_reset();
    for (int w = 1; w <= 6; w++) begin
      MOL = 9'(w);
      step(1024);
      if (w == 1) begin
        chk_bit("stall_w1_valid", bus.out_valid, 1'b1);
        chk("stall_w1_l", bus.out_l, 16'd32);
      end
      if (w == 4) chk_bit("stall_w4_ovf", OVF, 1'b0);
      if (w == 5) chk_bit("stall_w5_ovf", OVF, 1'b1);
    end
    EN = 1'b0;
    chk_bit("stall_w6_ovf", OVF, 1'b1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk_bit("ovf_cleared", OVF, 1'b0);
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk_bit($sformatf("drain%0d_valid", k), bus.out_valid, 1'b1);
      chk($sformatf("drain%0d_l", k), bus.out_l, 16'(32 * k));
      step(1);
    end
    chk_bit("drain_empty", bus.out_valid, 1'b0);

    // Full FIFO with a pop on the window-end edge: push accepted, no overflow.
    bus.out_ready = 1'b0;
    MOL = 9'd1; EN = 1'b1;
    apply_reset();
    for (int w = 1; w <= 4; w++) begin
      MOL = 9'(w);
      step(1024);
    end
    MOL = 9'd5;
    step(1023);
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;
    EN = 1'b0;
    chk_bit("fullpop_ovf", OVF, 1'b0);
    bus.out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk_bit($sformatf("fullpop%0d_valid", k), bus.out_valid, 1'b1);
      chk($sformatf("fullpop%0d_l", k), bus.out_l, 16'(32 * k));
      step(1);
    end
    chk_bit("fullpop_empty", bus.out_valid, 1'b0);

    // Asynchronous reset mid-window with data queued.
    bus.out_ready = 1'b0;
    MOL = 9'd1; EN = 1'b1;
    apply_reset();
    step(2048 + 500);
    chk_bit("sres_pre_valid", bus.out_valid, 1'b1);
    SRES = 1'b0;
    #1;
    chk_bit("sres_valid", bus.out_valid, 1'b0);
    chk("sres_out_l", bus.out_l, 16'h0000);
    chk_bit("sres_ovf", OVF, 1'b0);
    bus.out_ready = 1'b1;
    step(1);
    SRES = 1'b1;
    step(1023);
    chk_bit("sres_full_window", bus.out_valid, 1'b0);
    step(1);
    chk_bit("sres_next_valid", bus.out_valid, 1'b1);
    chk("sres_next_l", bus.out_l, 16'd32);

    // EN dropped mid-window: partial sum discarded, fresh 1024-cycle window.
    MOL = 9'h010; MOR = '0; PSG = 16'h8000; EN = 1'b1;
    apply_reset();
    step(700);
    EN = 1'b0;
    step(10);
    chk_bit("en_off_valid", bus.out_valid, 1'b0);
    EN = 1'b1;
    early = 0;
    for (int i = 0; i < 1024; i++) begin
      MOL = i[0] ? 9'h1F0 : 9'h010;
      if (bus.out_valid) early++;
      step(1);
    end
    chk("en_fresh_window", 16'(early), 16'd0);
    chk_bit("en_valid", bus.out_valid, 1'b1);
    chk("en_l", bus.out_l, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
